// File: rtl/cpi_muldiv_pkg.sv
// Shared definitions for the cpi multiply/divide coprocessor.
package cpi_muldiv_pkg;

  // op nibble claimed by default; 0..5 belong to the core
  localparam logic [3:0] COP_OP_DEF = 4'h6;

  // cpi_inst field positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int SUB_HI = 27;
  localparam int SUB_LO = 24;

  typedef enum logic [3:0] {
    SUB_MUL   = 4'd0,
    SUB_MULHU = 4'd1,
    SUB_DIVU  = 4'd2,
    SUB_REMU  = 4'd3,
    SUB_DIV   = 4'd4,
    SUB_REM   = 4'd5
  } subop_e;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // magnitude of a two's complement word; |-2^31| stays 32'h80000000
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic is_legal(input logic [3:0] s);
    return s <= 4'd5;
  endfunction

endpackage

// File: rtl/cpi_muldiv_iter.sv
// Iterative 64-bit shift datapath shared by multiply (shift-add, LSB first)
// and unsigned divide (restoring). {hi,lo} is the working register:
//   mul: lo = multiplier, hi = partial product; result {hi,lo}
//   div: lo = dividend -> quotient, hi = partial remainder
// Next-state values are exported so the top can register the result on
// the same edge that performs the final step.
module muldiv_iter
  import cpi_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        is_mul,
  input  logic [31:0] opnd,     // multiplicand or divisor
  input  logic [31:0] seed,     // multiplier or dividend
  output logic        last,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [31:0] hi, lo, opnd_q;
  logic [4:0]  cnt;
  logic        mul_q;
  logic [32:0] sum, sh, diff;

  assign last = (cnt == 5'd0);

  // one shift-add or restoring-subtract step
  always_comb begin
    sum    = '0;
    sh     = '0;
    diff   = '0;
    nxt_hi = hi;
    nxt_lo = lo;
    if (mul_q) begin
      // carry out of the 32-bit add lands in the product's top bit
      sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : 33'd0);
      {nxt_hi, nxt_lo} = {sum, lo[31:1]};
    end else begin
      sh   = {hi, lo[31]};
      diff = sh - {1'b0, opnd_q};
      nxt_hi = diff[32] ? sh[31:0] : diff[31:0];
      nxt_lo = {lo[30:0], ~diff[32]};
    end
  end

  // working registers and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= '0;
      lo     <= '0;
      opnd_q <= '0;
      cnt    <= '0;
      mul_q  <= 1'b0;
    end else if (start) begin
      hi     <= '0;
      lo     <= seed;
      opnd_q <= opnd;
      cnt    <= 5'd31;
      mul_q  <= is_mul;
    end else if (step) begin
      hi     <= nxt_hi;
      lo     <= nxt_lo;
      cnt    <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/cpi_muldiv.sv
// cpi coprocessor responder: multiply/divide over 32 iterations, holding
// cpi_wait so the CPU timeout is frozen. Owns the FSM, sign fix-up,
// divide-by-zero handling and the cpi handshake.
module cpi_muldiv
  import cpi_muldiv_pkg::*;
#(
  parameter logic [3:0] COP_OP      = COP_OP_DEF,
  parameter bit          ACK_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpi_valid,
  input  logic [31:0] cpi_inst,
  input  logic [31:0] cpi_r1,
  input  logic [31:0] cpi_r2,
  output logic        cpi_ready,
  output logic        cpi_wait,
  output logic [31:0] cpi_data,
  output logic        cpi_drop
);

  logic [1:0]  state;
  subop_e      sub_q;
  logic [31:0] r1_q;
  logic        neg_q, neg_r, div0;

  logic [3:0]  op, sub;
  logic        claim, accept, start_mul, is_signed;
  logic [31:0] it_opnd, it_seed, it_hi, it_lo, result;
  logic        it_last, it_step;
  logic        unused_inst;

  assign op          = cpi_inst[OP_HI:OP_LO];
  assign sub         = cpi_inst[SUB_HI:SUB_LO];
  assign unused_inst = ^cpi_inst[SUB_LO-1:0];
  assign claim       = (state == ST_IDLE) && cpi_valid && (op == COP_OP);
  assign accept      = claim && is_legal(sub);
  assign it_step     = (state == ST_BUSY) && cpi_valid;

  // operand routing into the shared datapath; signed ops use magnitudes
  always_comb begin
    start_mul = (sub == SUB_MUL) || (sub == SUB_MULHU);
    is_signed = (sub == SUB_DIV) || (sub == SUB_REM);
    if (start_mul) begin
      it_opnd = cpi_r1;
      it_seed = cpi_r2;
    end else begin
      it_opnd = is_signed ? abs32(cpi_r2) : cpi_r2;
      it_seed = is_signed ? abs32(cpi_r1) : cpi_r1;
    end
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .step   (it_step),
    .is_mul (start_mul),
    .opnd   (it_opnd),
    .seed   (it_seed),
    .last   (it_last),
    .nxt_hi (it_hi),
    .nxt_lo (it_lo)
  );

  // final result from the last step's next-state, with sign and /0 fix-up
  always_comb begin
    result = '0;
    case (sub_q)
      SUB_MUL:   result = it_lo;
      SUB_MULHU: result = it_hi;
      SUB_DIVU:  result = div0 ? 32'hFFFF_FFFF : it_lo;
      SUB_REMU:  result = div0 ? r1_q : it_hi;
      SUB_DIV:   result = div0 ? 32'hFFFF_FFFF : (neg_q ? (~it_lo + 32'd1) : it_lo);
      SUB_REM:   result = div0 ? r1_q : (neg_r ? (~it_hi + 32'd1) : it_hi);
      default:   result = '0;
    endcase
  end

  // handshake FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sub_q     <= SUB_MUL;
      r1_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      cpi_ready <= 1'b0;
      cpi_wait  <= 1'b0;
      cpi_data  <= '0;
      cpi_drop  <= 1'b0;
    end else begin
      cpi_ready <= 1'b0;
      cpi_drop  <= 1'b0;
      cpi_data  <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            cpi_wait <= 1'b1;
            sub_q    <= subop_e'(sub);
            r1_q     <= cpi_r1;
            neg_q    <= is_signed && (cpi_r1[31] ^ cpi_r2[31]);
            neg_r    <= is_signed && cpi_r1[31];
            div0     <= (cpi_r2 == 32'd0);
          end else if (claim && ACK_ILLEGAL) begin
            state     <= ST_DONE;
            cpi_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (!cpi_valid) begin
            // CPU gave up on this request
            state    <= ST_IDLE;
            cpi_wait <= 1'b0;
          end else if (it_last) begin
            state     <= ST_DONE;
            cpi_wait  <= 1'b0;
            cpi_ready <= 1'b1;
            cpi_drop  <= 1'b1;
            cpi_data  <= result;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state    <= ST_IDLE;
          cpi_wait <= 1'b0;
        end
      endcase
    end
  end

endmodule
